// File: rtl/eth_rx_ptp_ts_merge.sv
// Merges the RX PTP timestamp stream onto the received frame stream: every frame
// carries one timestamp on all of its beats, or a zero stamp if none arrives in time.
module eth_rx_ptp_ts_merge #(
    parameter int DATA_WIDTH   = 64,
    parameter int KEEP_WIDTH   = DATA_WIDTH / 8,
    parameter int PTP_TS_WIDTH = 96,
    parameter int TS_TIMEOUT   = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,

    input  logic [PTP_TS_WIDTH-1:0] s_axis_ptp_ts_96,
    input  logic                    s_axis_ptp_ts_valid,
    output logic                    s_axis_ptp_ts_ready,

    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic [PTP_TS_WIDTH-1:0] m_axis_ptp_ts_96,
    output logic                    m_axis_ptp_ts_valid,

    output logic                    ts_timeout,
    output logic                    dbg_in_frame
);

    // Handshakes: a beat or timestamp transfers on a rising edge where valid and
    // ready are both 1; a source keeps its payload stable while valid=1, ready=0.

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TS_TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [15:0]             wait_cnt_q, wait_cnt_d;
    logic                    run_q;
    logic [DATA_WIDTH-1:0]   tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0]   tkeep_q, tkeep_d;
    logic                    tlast_q, tlast_d;
    logic                    tuser_q, tuser_d;
    logic                    tvalid_q, tvalid_d;
    logic [PTP_TS_WIDTH-1:0] ts_q, ts_d;
    logic                    ts_valid_q, ts_valid_d;
    logic                    ts_timeout_q, ts_timeout_d;

    logic can_accept;
    logic timed_out;
    logic s_ready;
    logic ts_ready;
    logic s_xfer;
    logic start_xfer;

    always_comb begin
        can_accept   = ~tvalid_q | m_axis_tready;
        timed_out    = (wait_cnt_q >= TIMEOUT_LAST);
        s_ready      = 1'b0;
        ts_ready     = 1'b0;

        // run_q keeps both readies low until the first edge after reset release.
        case (state_q)
            ST_IDLE: begin
                s_ready  = run_q & can_accept & (s_axis_ptp_ts_valid | timed_out);
                ts_ready = run_q & can_accept & s_axis_tvalid & s_axis_ptp_ts_valid;
            end
            ST_FRAME: s_ready = run_q & can_accept;
            default: ;
        endcase

        s_xfer     = s_axis_tvalid & s_ready;
        start_xfer = s_xfer & (state_q == ST_IDLE);

        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        tdata_d      = tdata_q;
        tkeep_d      = tkeep_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        tvalid_d     = tvalid_q;
        ts_d         = ts_q;
        ts_valid_d   = ts_valid_q;
        ts_timeout_d = 1'b0;

        if (s_xfer) begin
            state_d  = s_axis_tlast ? ST_IDLE : ST_FRAME;
            tdata_d  = s_axis_tdata;
            tkeep_d  = s_axis_tkeep;
            tlast_d  = s_axis_tlast;
            tuser_d  = s_axis_tuser;
            tvalid_d = 1'b1;
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        // A timestamp present on the release cycle always wins over the timeout.
        if (start_xfer) begin
            ts_d         = s_axis_ptp_ts_valid ? s_axis_ptp_ts_96 : '0;
            ts_valid_d   = s_axis_ptp_ts_valid;
            ts_timeout_d = ~s_axis_ptp_ts_valid;
        end

        if (state_q == ST_FRAME || start_xfer) begin
            wait_cnt_d = '0;
        end else if (s_axis_tvalid && !s_axis_ptp_ts_valid && wait_cnt_q != 16'hFFFF) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= '0;
            run_q        <= 1'b0;
            tdata_q      <= '0;
            tkeep_q      <= '0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            tvalid_q     <= 1'b0;
            ts_q         <= '0;
            ts_valid_q   <= 1'b0;
            ts_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            run_q        <= 1'b1;
            tdata_q      <= tdata_d;
            tkeep_q      <= tkeep_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            tvalid_q     <= tvalid_d;
            ts_q         <= ts_d;
            ts_valid_q   <= ts_valid_d;
            ts_timeout_q <= ts_timeout_d;
        end
    end

    assign s_axis_tready       = s_ready;
    assign s_axis_ptp_ts_ready = ts_ready;
    assign m_axis_tdata        = tdata_q;
    assign m_axis_tkeep        = tkeep_q;
    assign m_axis_tvalid       = tvalid_q;
    assign m_axis_tlast        = tlast_q;
    assign m_axis_tuser        = tuser_q;
    assign m_axis_ptp_ts_96    = ts_q;
    assign m_axis_ptp_ts_valid = ts_valid_q;
    assign ts_timeout          = ts_timeout_q;
    assign dbg_in_frame        = (state_q == ST_FRAME);

endmodule

// File: tb/tb_eth_rx_ptp_ts_merge.sv
// Self-checking bench for eth_rx_ptp_ts_merge: scenario tasks drive frames and
// timestamps, a monitor collects output beats, expectations come from frame order.
module tb_eth_rx_ptp_ts_merge;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int TW = 96;
  localparam int TO = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
    logic [TW-1:0] ts;
    logic          tsv;
    int            cyc;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid, s_tready, s_tlast, s_tuser;
  logic [TW-1:0] s_ts;
  logic          s_ts_valid, s_ts_ready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_tready, m_tlast, m_tuser;
  logic [TW-1:0] m_ts;
  logic          m_ts_valid;
  logic          ts_timeout;
  logic          dbg_in_frame;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  beat_t obs_q[$];
  beat_t exp_q[$];
  int    acc_q[$];

  beat_t mon_b, prev_b;
  logic  prev_stall = 1'b0;
  logic  prev_to = 1'b0;
  int    timeout_pulses = 0;
  int    double_pulses = 0;
  int    stall_viol = 0;

  eth_rx_ptp_ts_merge #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .PTP_TS_WIDTH(TW), .TS_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .s_axis_ptp_ts_96(s_ts), .s_axis_ptp_ts_valid(s_ts_valid), .s_axis_ptp_ts_ready(s_ts_ready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .m_axis_ptp_ts_96(m_ts), .m_axis_ptp_ts_valid(m_ts_valid),
    .ts_timeout(ts_timeout), .dbg_in_frame(dbg_in_frame)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_to = 1'b0;
    end else begin
      mon_b.data = m_tdata;
      mon_b.keep = m_tkeep;
      mon_b.last = m_tlast;
      mon_b.user = m_tuser;
      mon_b.ts = m_ts;
      mon_b.tsv = m_ts_valid;
      mon_b.cyc = cyc;
      if (prev_stall) begin
        if (m_tvalid !== 1'b1 || mon_b.data !== prev_b.data || mon_b.keep !== prev_b.keep ||
            mon_b.last !== prev_b.last || mon_b.user !== prev_b.user ||
            mon_b.ts !== prev_b.ts || mon_b.tsv !== prev_b.tsv)
          stall_viol++;
      end
      if (m_tvalid === 1'b1 && m_tready === 1'b1) obs_q.push_back(mon_b);
      if (ts_timeout === 1'b1) begin
        timeout_pulses++;
        if (prev_to) double_pulses++;
      end
      prev_to = ts_timeout;
      prev_stall = m_tvalid && !m_tready;
      prev_b = mon_b;
    end
  end

  function automatic bit beat_eq(input beat_t a, input beat_t b);
    return (a.data === b.data) && (a.keep === b.keep) && (a.last === b.last) &&
           (a.user === b.user) && (a.ts === b.ts) && (a.tsv === b.tsv);
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                            input logic l, input logic u);
    int n;
    n = 0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    @(negedge clk);
    while (s_tready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL beat_handshake: s_axis_tready low for %0d cycles, required a transfer", n);
    end else begin
      acc_q.push_back(cyc);
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic drive_ts(input logic [TW-1:0] t);
    int n;
    n = 0;
    s_ts = t; s_ts_valid = 1'b1;
    @(negedge clk);
    while (s_ts_ready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL ts_handshake: s_axis_ptp_ts_ready low for %0d cycles, required a transfer", n);
    end
    @(posedge clk); #1;
    s_ts_valid = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [TW-1:0] ts, input logic tsv,
                            input int max_gap);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
      b.data = {$urandom, $urandom};
      b.last = (i == len - 1);
      if (b.last) begin
        b.keep = KW'($urandom_range(255, 1));
        b.user = 1'($urandom_range(1, 0));
      end else begin
        b.keep = '1;
        b.user = 1'b0;
      end
      b.ts = ts;
      b.tsv = tsv;
      b.cyc = 0;
      exp_q.push_back(b);
      drive_beat(b.data, b.keep, b.last, b.user);
    end
  endtask

  task automatic wait_obs(input int base, input int n, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if (obs_q.size() >= base + n) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL output_wait: saw %0d output beats, required %0d", obs_q.size() - base, n);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    s_tvalid = 1'b1; s_ts_valid = 1'b1; m_tready = 1'b1;
    s_tdata = {$urandom, $urandom}; s_ts = {$urandom, $urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, m_ts, m_ts_valid, ts_timeout, dbg_in_frame} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got tvalid=%b tdata=%h ts=%h tsv=%b to=%b, required all 0",
               m_tvalid, m_tdata, m_ts, m_ts_valid, ts_timeout);
    end
    checks++;
    if (s_tready !== 1'b0 || s_ts_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got s_tready=%b ts_ready=%b, required 0 0", s_tready, s_ts_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (s_tready !== 1'b0 || s_ts_ready !== 1'b0) begin
      errors++;
      $display("FAIL release_sync: got s_tready=%b ts_ready=%b before first edge, required 0 0",
               s_tready, s_ts_ready);
    end
    s_tvalid = 1'b0; s_ts_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int ob, eb, ab;
    bit ok;
    logic [TW-1:0] t;
    ob = obs_q.size(); eb = exp_q.size(); ab = acc_q.size();
    t = 96'h0000_0001_0000_0002_0000_0003;
    m_tready = 1'b1;
    fork
      drive_ts(t);
      send_frame(3, t, 1'b1, 0);
    join
    wait_obs(ob, 3, ok);
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (!beat_eq(obs_q[ob + i], exp_q[eb + i])) begin
          errors++;
          $display("FAIL basic_beat %0d: got data=%h ts=%h tsv=%b last=%b, required data=%h ts=%h tsv=%b last=%b",
                   i, obs_q[ob + i].data, obs_q[ob + i].ts, obs_q[ob + i].tsv, obs_q[ob + i].last,
                   exp_q[eb + i].data, exp_q[eb + i].ts, exp_q[eb + i].tsv, exp_q[eb + i].last);
        end
        checks++;
        if (obs_q[ob + i].cyc - acc_q[ab + i] != 1) begin
          errors++;
          $display("FAIL basic_latency %0d: got %0d cycles, required 1", i, obs_q[ob + i].cyc - acc_q[ab + i]);
        end
      end
    end
  endtask

  task automatic test_ts_delay;
    int ob, stalls, to0;
    bit ok;
    logic [TW-1:0] t;
    ob = obs_q.size(); to0 = timeout_pulses; stalls = 0;
    t = {$urandom, $urandom, $urandom};
    m_tready = 1'b1;
    fork
      send_frame(2, t, 1'b1, 0);
      begin
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (s_tready === 1'b0) stalls++;
          @(posedge clk); #1;
        end
        drive_ts(t);
      end
    join
    checks++;
    if (stalls != 10) begin
      errors++;
      $display("FAIL delay_stall: got %0d stalled cycles, required 10", stalls);
    end
    wait_obs(ob, 2, ok);
    if (ok) begin
      checks++;
      if (obs_q[ob].ts !== t || obs_q[ob].tsv !== 1'b1 || obs_q[ob + 1].ts !== t || obs_q[ob + 1].tsv !== 1'b1) begin
        errors++;
        $display("FAIL delay_ts: got ts=%h/%h tsv=%b/%b, required ts=%h tsv=1",
                 obs_q[ob].ts, obs_q[ob + 1].ts, obs_q[ob].tsv, obs_q[ob + 1].tsv, t);
      end
    end
    checks++;
    if (timeout_pulses != to0) begin
      errors++;
      $display("FAIL delay_no_timeout: got %0d pulses, required 0", timeout_pulses - to0);
    end
  endtask

  task automatic test_timeout;
    int ob, n, to0, dp0;
    bit ok;
    logic [TW-1:0] tb_ts, tc_ts;
    ob = obs_q.size(); to0 = timeout_pulses; dp0 = double_pulses; n = 0;
    tb_ts = {$urandom, $urandom, $urandom};
    tc_ts = {$urandom, $urandom, $urandom};
    m_tready = 1'b1;
    fork
      send_frame(2, '0, 1'b0, 0);
      begin
        @(negedge clk);
        while (s_tready !== 1'b1 && n < 200) begin
          n++;
          @(negedge clk);
        end
      end
    join
    checks++;
    if (n != TO - 1) begin
      errors++;
      $display("FAIL timeout_stall: got %0d stalled cycles, required %0d", n, TO - 1);
    end
    wait_obs(ob, 2, ok);
    if (ok) begin
      checks++;
      if (obs_q[ob].ts !== '0 || obs_q[ob].tsv !== 1'b0 || obs_q[ob + 1].ts !== '0 || obs_q[ob + 1].tsv !== 1'b0) begin
        errors++;
        $display("FAIL timeout_ts: got ts=%h tsv=%b, required ts=0 tsv=0", obs_q[ob].ts, obs_q[ob].tsv);
      end
    end
    checks++;
    if (timeout_pulses - to0 != 1 || double_pulses != dp0) begin
      errors++;
      $display("FAIL timeout_pulse: got %0d pulses (%0d long), required 1 single-cycle",
               timeout_pulses - to0, double_pulses - dp0);
    end
    // a timestamp offered afterwards belongs to the following frame
    ob = obs_q.size();
    fork
      drive_ts(tb_ts);
      send_frame(1, tb_ts, 1'b1, 0);
    join
    wait_obs(ob, 1, ok);
    if (ok) begin
      checks++;
      if (obs_q[ob].ts !== tb_ts || obs_q[ob].tsv !== 1'b1) begin
        errors++;
        $display("FAIL late_ts: got ts=%h tsv=%b, required ts=%h tsv=1", obs_q[ob].ts, obs_q[ob].tsv, tb_ts);
      end
    end
    // timestamp arriving exactly on the release cycle
    ob = obs_q.size(); to0 = timeout_pulses;
    fork
      send_frame(1, tc_ts, 1'b1, 0);
      begin
        repeat (TO - 1) begin @(posedge clk); #1; end
        drive_ts(tc_ts);
      end
    join
    wait_obs(ob, 1, ok);
    if (ok) begin
      checks++;
      if (obs_q[ob].ts !== tc_ts || obs_q[ob].tsv !== 1'b1) begin
        errors++;
        $display("FAIL edge_ts: got ts=%h tsv=%b, required ts=%h tsv=1", obs_q[ob].ts, obs_q[ob].tsv, tc_ts);
      end
    end
    checks++;
    if (timeout_pulses != to0) begin
      errors++;
      $display("FAIL edge_no_timeout: got %0d pulses, required 0", timeout_pulses - to0);
    end
  endtask

  task automatic test_back_to_back;
    int ob, eb;
    bit ok;
    logic [TW-1:0] ta, tb2;
    ob = obs_q.size(); eb = exp_q.size();
    ta = {$urandom, $urandom, $urandom};
    tb2 = {$urandom, $urandom, $urandom};
    m_tready = 1'b1;
    fork
      begin drive_ts(ta); drive_ts(tb2); end
      begin send_frame(1, ta, 1'b1, 0); send_frame(1, tb2, 1'b1, 0); end
    join
    wait_obs(ob, 2, ok);
    if (ok) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (!beat_eq(obs_q[ob + i], exp_q[eb + i])) begin
          errors++;
          $display("FAIL b2b_frame %0d: got data=%h ts=%h tsv=%b, required data=%h ts=%h tsv=1",
                   i, obs_q[ob + i].data, obs_q[ob + i].ts, obs_q[ob + i].tsv, exp_q[eb + i].data, exp_q[eb + i].ts);
        end
      end
      checks++;
      if (obs_q[ob + 1].cyc - obs_q[ob].cyc != 1) begin
        errors++;
        $display("FAIL b2b_bubble: got %0d cycles between frames, required 1", obs_q[ob + 1].cyc - obs_q[ob].cyc);
      end
    end
  endtask

  task automatic test_random;
    int ob, eb, total, to0, sv0;
    bit ok, done;
    logic [TW-1:0] ts_list[100];
    int len_list[100];
    ob = obs_q.size(); eb = exp_q.size(); to0 = timeout_pulses; sv0 = stall_viol;
    total = 0; done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      ts_list[i] = {$urandom, $urandom, $urandom};
      len_list[i] = $urandom_range(20, 1);
      total += len_list[i];
    end
    fork
      begin
        fork
          for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
            drive_ts(ts_list[i]);
          end
          for (int j = 0; j < 100; j++) send_frame(len_list[j], ts_list[j], 1'b1, 1);
        join
        done = 1'b1;
      end
      while (!done) begin
        @(posedge clk); #1;
        m_tready = 1'($urandom_range(1, 0));
      end
    join
    m_tready = 1'b1;
    wait_obs(ob, total, ok);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (obs_q.size() - ob != total) begin
      errors++;
      $display("FAIL random_count: got %0d beats, required %0d", obs_q.size() - ob, total);
    end
    if (ok) begin
      for (int i = 0; i < total; i++) begin
        checks++;
        if (!beat_eq(obs_q[ob + i], exp_q[eb + i])) begin
          errors++;
          $display("FAIL random_beat %0d: got data=%h keep=%h last=%b user=%b ts=%h tsv=%b, required data=%h keep=%h last=%b user=%b ts=%h tsv=%b",
                   i, obs_q[ob + i].data, obs_q[ob + i].keep, obs_q[ob + i].last, obs_q[ob + i].user,
                   obs_q[ob + i].ts, obs_q[ob + i].tsv, exp_q[eb + i].data, exp_q[eb + i].keep,
                   exp_q[eb + i].last, exp_q[eb + i].user, exp_q[eb + i].ts, exp_q[eb + i].tsv);
        end
      end
    end
    checks++;
    if (stall_viol != sv0) begin
      errors++;
      $display("FAIL random_stall_stable: got %0d unstable stalled cycles, required 0", stall_viol - sv0);
    end
    checks++;
    if (timeout_pulses != to0) begin
      errors++;
      $display("FAIL random_no_timeout: got %0d pulses, required 0", timeout_pulses - to0);
    end
  endtask

  task automatic test_reset_mid;
    int ob, eb;
    bit ok;
    logic [TW-1:0] t1, t2;
    t1 = {$urandom, $urandom, $urandom};
    t2 = {$urandom, $urandom, $urandom};
    m_tready = 1'b1;
    fork
      drive_ts(t1);
      begin
        drive_beat({$urandom, $urandom}, '1, 1'b0, 1'b0);
        drive_beat({$urandom, $urandom}, '1, 1'b0, 1'b0);
      end
    join
    s_tdata = {$urandom, $urandom}; s_tkeep = '1; s_tlast = 1'b0; s_tuser = 1'b0; s_tvalid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({m_tvalid, m_tdata, m_tkeep, m_tlast, m_tuser, m_ts, m_ts_valid, ts_timeout} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got tvalid=%b tdata=%h ts=%h tsv=%b, required all 0",
               m_tvalid, m_tdata, m_ts, m_ts_valid);
    end
    checks++;
    if (s_tready !== 1'b0 || s_ts_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ready: got s_tready=%b ts_ready=%b, required 0 0", s_tready, s_ts_ready);
    end
    s_tvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    ob = obs_q.size(); eb = exp_q.size();
    fork
      drive_ts(t2);
      send_frame(3, t2, 1'b1, 0);
    join
    wait_obs(ob, 3, ok);
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (!beat_eq(obs_q[ob + i], exp_q[eb + i])) begin
          errors++;
          $display("FAIL midreset_beat %0d: got data=%h ts=%h tsv=%b last=%b, required data=%h ts=%h tsv=1 last=%b",
                   i, obs_q[ob + i].data, obs_q[ob + i].ts, obs_q[ob + i].tsv, obs_q[ob + i].last,
                   exp_q[eb + i].data, exp_q[eb + i].ts, exp_q[eb + i].last);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
    s_ts = '0; s_ts_valid = 1'b0; m_tready = 1'b0;
    test_reset();
    test_basic();
    test_ts_delay();
    test_timeout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
